// File: rtl/mips_pkg.sv
// mips_pkg: shared writeback-arbiter types, register constants and default sizing.
package mips_pkg;
  typedef enum logic {ST_NORMAL, ST_DRAIN} wb_state_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_FIFO_DEPTH = 2;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding MDU results with full, empty and occupancy count.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between pipeline writeback
// and queued MDU results, with starvation drain, RAW scoreboard and sticky error flag.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  wb_state_t      r_state;
  logic           r_run;
  logic [SW-1:0]  r_starve;
  logic [31:0]    r_sb;
  wb_entry_t      w_head, w_in;
  logic           w_full, w_empty, w_push, w_pop, w_pipe_sel, w_err_evt;
  logic [CW-1:0]  w_count;
  logic [SW-1:0]  w_starve_nxt;
  logic [31:0]    w_set, w_clr;
  assign w_in = '{rd: mdu_rd, data: mdu_data};
  wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_in),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // r_run holds the port quiet until the first edge after reset release
  assign mdu_ready  = r_run && !w_full;
  assign w_push     = mdu_valid && mdu_ready;
  assign w_pipe_sel = r_state == ST_NORMAL && pipe_we;
  assign w_pop      = !w_empty && !w_pipe_sel;
  assign rf_waddr   = w_pipe_sel ? pipe_waddr : w_head.rd;
  assign rf_wdata   = w_pipe_sel ? pipe_wdata : w_head.data;
  assign rf_we      = r_run && (w_pipe_sel ? pipe_waddr != REG_ZERO : w_pop && w_head.rd != REG_ZERO);
  assign hazard1    = r_sb[rd_addr1];
  assign hazard2    = r_sb[rd_addr2];
  assign w_starve_nxt = w_pop ? '0 :
                        (w_count != '0 && r_starve != SW'(STARVE_LIMIT)) ? r_starve + SW'(1) : r_starve;
  assign w_set = (mdu_issue && mdu_issue_rd != REG_ZERO) ? 32'd1 << mdu_issue_rd : '0;
  assign w_clr = w_pop ? 32'd1 << w_head.rd : '0;
  assign w_err_evt = (mdu_issue && r_sb[mdu_issue_rd]) || (pipe_we && stall) || (mdu_valid && !r_sb[mdu_rd]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_NORMAL;
      stall    <= 1'b0;
      r_run    <= 1'b0;
      r_starve <= '0;
      r_sb     <= '0;
      err      <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_starve <= w_starve_nxt;
      r_sb     <= (r_sb & ~w_clr) | w_set;
      err      <= err | w_err_evt;
      if (r_state == ST_NORMAL && w_starve_nxt == SW'(STARVE_LIMIT)) begin
        r_state <= ST_DRAIN;
        stall   <= 1'b1;
      end else if (r_state == ST_DRAIN && w_empty) begin
        r_state <= ST_NORMAL;
        stall   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with hand-computed expectations.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        hazard1, hazard2, stall, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int checks = 0;
  int failures = 0;

  regfile_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_waddr   (pipe_waddr),
    .pipe_wdata   (pipe_wdata),
    .mdu_issue    (mdu_issue),
    .mdu_issue_rd (mdu_issue_rd),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .stall        (stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    mdu_issue = 1'b1;
    mdu_issue_rd = rd;
    step();
    mdu_issue = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1234;
    mdu_issue = 1'b0; mdu_issue_rd = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    repeat (3) step();
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_ready", mdu_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_rf_we_pre_edge", rf_we, 0);
    step();
    chk("rel_rf_we", rf_we, 1);
    chk("rel_waddr", rf_waddr, 3);
    chk("rel_ready", mdu_ready, 1);
    pipe_we = 1'b0;

    // basic MDU writeback to r5
    rd_addr1 = 5'd5;
    issue(5'd5);
    chk("r5_haz_set", hazard1, 1);
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hDEADBEEF;
    chk("r5_ready", mdu_ready, 1);
    step();
    mdu_valid = 1'b0;
    chk("r5_rf_we", rf_we, 1);
    chk("r5_waddr", rf_waddr, 5);
    chk("r5_wdata", rf_wdata, 32'hDEADBEEF);
    chk("r5_haz_hold", hazard1, 1);
    step();
    chk("r5_haz_clr", hazard1, 0);
    chk("r5_rf_we_idle", rf_we, 0);
    chk("r5_err", err, 0);

    // register zero never set and never written
    mdu_issue = 1'b1; mdu_issue_rd = 5'd0;
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hFFFF;
    rd_addr1 = 5'd0;
    #1;
    chk("r0_rf_we", rf_we, 0);
    step();
    mdu_issue = 1'b0; pipe_we = 1'b0;
    chk("r0_haz", hazard1, 0);
    chk("r0_err", err, 0);

    // starvation: pipeline writes every cycle until drain stall
    rd_addr2 = 5'd9;
    issue(5'd9);
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    step();
    mdu_valid = 1'b0;
    chk("sv_pipe_wins", rf_waddr, 3);
    repeat (3) step();
    chk("sv_stall_wait3", stall, 0);
    step();
    chk("sv_stall_up", stall, 1);
    pipe_we = 1'b0;
    #1;
    chk("sv_drain_we", rf_we, 1);
    chk("sv_drain_waddr", rf_waddr, 9);
    chk("sv_drain_wdata", rf_wdata, 32'h99);
    step();
    chk("sv_stall_empty", stall, 1);
    chk("sv_rf_we_empty", rf_we, 0);
    chk("sv_haz9", hazard2, 0);
    step();
    chk("sv_stall_down", stall, 0);
    chk("sv_err", err, 0);

    // full FIFO back-pressure
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    pipe_we = 1'b1; pipe_waddr = 5'd4;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA;
    step();
    mdu_rd = 5'd11; mdu_data = 32'hB;
    step();
    mdu_rd = 5'd12; mdu_data = 32'hC;
    #1;
    chk("full_ready", mdu_ready, 0);
    step();
    chk("full_ready_hold", mdu_ready, 0);
    pipe_we = 1'b0;
    #1;
    chk("full_pop_waddr", rf_waddr, 10);
    chk("full_pop_wdata", rf_wdata, 32'hA);
    chk("full_ready_on_pop", mdu_ready, 0);
    step();
    chk("full_ready_after", mdu_ready, 1);
    chk("full_pop2_waddr", rf_waddr, 11);
    step();
    mdu_valid = 1'b0;
    #1;
    chk("full_third_waddr", rf_waddr, 12);
    chk("full_third_wdata", rf_wdata, 32'hC);
    step();
    rd_addr1 = 5'd12; rd_addr2 = 5'd10;
    #1;
    chk("full_haz12", hazard1, 0);
    chk("full_haz10", hazard2, 0);
    chk("full_err", err, 0);

    // set wins over clear on r7
    rd_addr1 = 5'd7;
    issue(5'd7);
    pipe_we = 1'b1; pipe_waddr = 5'd2;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
    step();
    mdu_valid = 1'b0; pipe_we = 1'b0;
    mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
    #1;
    chk("r7_pop_waddr", rf_waddr, 7);
    step();
    mdu_issue = 1'b0;
    chk("r7_haz_kept", hazard1, 1);
    chk("r7_err_dup_issue", err, 1);
    step();
    chk("r7_err_sticky", err, 1);

    // async reset with two queued entries
    issue(5'd20);
    issue(5'd21);
    pipe_we = 1'b1; pipe_waddr = 5'd1;
    mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h20;
    step();
    mdu_rd = 5'd21; mdu_data = 32'h21;
    step();
    mdu_valid = 1'b0;
    chk("ar_full", mdu_ready, 0);
    rd_addr1 = 5'd20; rd_addr2 = 5'd7;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_stall", stall, 0);
    chk("ar_err", err, 0);
    chk("ar_haz20", hazard1, 0);
    chk("ar_haz7", hazard2, 0);
    chk("ar_rf_we", rf_we, 0);
    pipe_we = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("ar_ready", mdu_ready, 1);
    chk("ar_fifo_empty", rf_we, 0);
    chk("ar_stall_after", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Parameters
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning cycles a queued MDU result may wait before the pipeline is stalled to drain the queue.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning MDU result holding-queue entries (power of two, >=2).

Interface
REQ-003 SHALL have clk input 1: single clock; all state updates on posedge.
REQ-004 SHALL have rst input 1: reset, asynchronous, active-high.
REQ-005 SHALL have pipe_we, pipe_waddr, pipe_wdata inputs of widths 1, 5 and 32: pipeline writeback request, target register and data.
REQ-006 SHALL have mdu_issue and mdu_issue_rd inputs of widths 1 and 5: a multi-cycle op was issued targeting mdu_issue_rd.
REQ-007 SHALL have mdu_valid input 1, mdu_rd input 5, mdu_data input 32 and mdu_ready output 1: MDU result valid/ready handshake.
REQ-008 SHALL have rd_addr1 and rd_addr2 inputs of width 5 each: pipeline source registers for hazard check.
REQ-009 SHALL have hazard1 and hazard2 outputs of width 1 each: the source register has an outstanding MDU write.
REQ-010 SHALL have stall output 1: pipeline must hold; the pipeline guarantees pipe_we=0 while stall=1.
REQ-011 SHALL have rf_we, rf_waddr and rf_wdata outputs of widths 1, 5 and 32: driven to the register-file write port (RegWriteSignal, WriteReg, WriteData).
REQ-012 SHALL have err output 1: sticky protocol-error flag.

Function
REQ-013 SHALL accept an MDU result when mdu_valid and mdu_ready are both high at posedge, pushing {mdu_rd, mdu_data} into the FIFO; mdu_ready = FIFO not full.
REQ-014 SHALL select the write port combinationally: in NORMAL, pipe_we=1 wins; otherwise the FIFO head is written and popped at that posedge.
REQ-015 SHALL suppress any write whose address is 0 (rf_we=0); a FIFO entry with rd=0 SHALL still be popped and SHALL count as written.
REQ-016 SHALL implement FSM NORMAL/DRAIN: NORMAL->DRAIN when starve_cnt reaches STARVE_LIMIT; DRAIN->NORMAL on the cycle after the FIFO becomes empty.
REQ-017 SHALL increment starve_cnt each cycle the FIFO is non-empty and no pop occurs, clear it on any pop, and saturate at STARVE_LIMIT.
REQ-018 SHALL drive stall registered: high for the whole of DRAIN and low in NORMAL; in DRAIN the FIFO head SHALL always be written.
REQ-019 SHALL keep a 32-bit scoreboard: mdu_issue sets bit mdu_issue_rd (bit 0 is never set); a FIFO pop clears bit rd.
REQ-020 SHALL, when set and clear of the same bit coincide, let the set win.
REQ-021 SHALL drive hazard1 = scoreboard[rd_addr1] and hazard2 = scoreboard[rd_addr2] combinationally from registered state.
REQ-022 SHALL set err if any of these occur: mdu_issue targets a bit already set; pipe_we=1 while stall=1; mdu_valid=1 with mdu_rd whose scoreboard bit is clear. err clears only on reset.
REQ-023 SHALL, with simultaneous push and pop on a full FIFO, not accept the push (mdu_ready stays low that cycle).

Reset
REQ-024 SHALL, while rst is high, clear FIFO pointers and count, starve_cnt, scoreboard and err, and force state NORMAL and stall=0.
REQ-025 SHALL discard queued results on reset mid-operation; mdu_ready SHALL be 1 and rf_we SHALL follow pipe_we only from the first posedge after release.

Structure
REQ-026 SHALL place the FSM state encoding, the REG_ZERO constant and the default parameter values in shared package mips_pkg.
REQ-027 SHALL instantiate one sub-module wb_fifo (synchronous FIFO with full, empty and count) for the result queue; arbitration, FSM and scoreboard stay in the top module.

Verification
REQ-028 SHALL verify: mdu_issue rd=5; then mdu_valid rd=5 data=0xDEADBEEF with pipe_we=0 -> rf_we=1, waddr=5, wdata=0xDEADBEEF next cycle, and hazard for r5 drops after the pop.
REQ-029 SHALL verify: pipe_we=1 continuously with MDU result queued -> stall rises after 4 waiting cycles, FIFO drains, stall falls the cycle after empty.
REQ-030 SHALL verify: mdu_issue rd=0 and pipe_we waddr=0 -> scoreboard unchanged and rf_we=0.
REQ-031 SHALL verify: FIFO filled with 2 entries under pipe_we=1 -> mdu_ready=0; third result held until a pop.
REQ-032 SHALL verify: pop of rd=7 coinciding with mdu_issue rd=7 -> hazard for r7 stays 1.
REQ-033 SHALL verify: rst asserted asynchronously with 2 queued entries -> FIFO empty, stall=0, err=0 and scoreboard 0 immediately.
